// File: rtl/mod_display_scan_scheduler.sv
// Four-digit seven-segment scan scheduler: double-buffered digit values,
// prescaled slot timing, inter-digit blanking, leading-zero blanking and a
// frame-done strobe. All outputs are registered.
module mod_display_scan_scheduler #(
    parameter int CLK_DIV     = 50000,
    parameter int SLOT_TICKS  = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       lzb,
    input  logic       colon,
    input  logic       wr_en,
    input  logic [1:0] wr_digit,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    output logic [3:0] anode,
    output logic [8:0] cathode,
    output logic       frame_done,
    output logic [1:0] cur_digit
);
    localparam int PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int MAXT = (SLOT_TICKS > BLANK_TICKS) ? SLOT_TICKS : BLANK_TICKS;
    localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [TW-1:0] SLOT_LAST  = TW'(SLOT_TICKS - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

    typedef enum logic [1:0] {IDLE, ON, BLANK} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   presc, presc_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic [1:0]      digit_n;
    logic            tick, phase_end, copy, fd_n;
    logic [3:0][3:0] shadow_val, act_val, act_val_n;
    logic [3:0]      shadow_dp, act_dp, act_dp_n;
    logic [3:0]      lz_mask;
    logic [3:0]      anode_n;
    logic [8:0]      cathode_n;

    // Active-low hex decode, bit 0 = segment a.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    // Next state, prescaler/tick counter, digit advance and frame boundary.
    always_comb begin
        state_n   = state;
        presc_n   = presc;
        tcnt_n    = tcnt;
        digit_n   = cur_digit;
        copy      = 1'b0;
        fd_n      = 1'b0;
        phase_end = 1'b0;
        tick      = (presc == PRESC_LAST);
        case (state)
            IDLE: begin
                presc_n = '0;
                tcnt_n  = '0;
                digit_n = 2'd0;
                if (en) begin
                    state_n = ON;
                    copy    = 1'b1;
                end
            end
            ON, BLANK: begin
                presc_n = tick ? '0 : presc + 1'b1;
                if (tick) begin
                    phase_end = (state == ON) ? (tcnt == SLOT_LAST) : (tcnt == BLANK_LAST);
                    tcnt_n    = phase_end ? '0 : tcnt + 1'b1;
                end
                if (phase_end) begin
                    if (state == ON && BLANK_TICKS > 0) begin
                        state_n = BLANK;
                    end else begin
                        state_n = ON;
                        digit_n = cur_digit + 2'd1;
                        // Wrapping 3 -> 0 is the frame boundary: latch the shadow set.
                        if (cur_digit == 2'd3) begin
                            copy = 1'b1;
                            fd_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Disable wins from any state and abandons the frame silently.
        if (!en) begin
            state_n = IDLE;
            presc_n = '0;
            tcnt_n  = '0;
            digit_n = 2'd0;
            copy    = 1'b0;
            fd_n    = 1'b0;
        end
    end

    // Output image for the upcoming cycle, decoded from the post-edge active set.
    always_comb begin
        act_val_n  = copy ? shadow_val : act_val;
        act_dp_n   = copy ? shadow_dp : act_dp;
        lz_mask[0] = 1'b0;
        lz_mask[3] = lzb && (act_val_n[3] == 4'h0);
        lz_mask[2] = lz_mask[3] && (act_val_n[2] == 4'h0);
        lz_mask[1] = lz_mask[2] && (act_val_n[1] == 4'h0);
        anode_n    = 4'hF;
        cathode_n  = 9'h1FF;
        if (state_n == ON && !lz_mask[digit_n]) begin
            anode_n[digit_n] = 1'b0;
            cathode_n = {(digit_n == 2'd1) ? ~colon : 1'b1, ~act_dp_n[digit_n], seg7(act_val_n[digit_n])};
        end
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            presc      <= '0;
            tcnt       <= '0;
            cur_digit  <= 2'd0;
            anode      <= 4'hF;
            cathode    <= 9'h1FF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            tcnt       <= tcnt_n;
            cur_digit  <= digit_n;
            anode      <= anode_n;
            cathode    <= cathode_n;
            frame_done <= fd_n;
        end
    end

    // Shadow digit registers, writable in any state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
        end else if (wr_en) begin
            shadow_val[wr_digit] <= wr_data;
            shadow_dp[wr_digit]  <= wr_dp;
        end
    end

    // Active set, loaded from the pre-edge shadow on scan start or frame boundary.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            act_val <= '0;
            act_dp  <= '0;
        end else begin
            act_val <= act_val_n;
            act_dp  <= act_dp_n;
        end
    end
endmodule

// File: tb/tb_mod_display_scan_scheduler.sv
// Scoreboard bench: each scenario pushes the expected per-cycle outputs and
// then drains the queue against the DUT one clock at a time.
module tb_mod_display_scan_scheduler;
    logic       clk = 1'b0;
    logic       reset, en, lzb, colon, wr_en, wr_dp;
    logic [1:0] wr_digit;
    logic [3:0] wr_data;
    logic [3:0] anode, anode_nb;
    logic [8:0] cathode, cathode_nb;
    logic       frame_done, frame_done_nb;
    logic [1:0] cur_digit, cur_digit_nb;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [8:0] cat;
        logic       fd;
        logic [1:0] dig;
    } exp_t;

    exp_t q[$];

    // Expected cathodes for shadow {3:8, 2:1, 1:0, 0:F}.
    localparam logic [3:0][8:0] STD = {9'h180, 9'h1F9, 9'h1C0, 9'h18E};

    mod_display_scan_scheduler #(.CLK_DIV(2), .SLOT_TICKS(3), .BLANK_TICKS(1)) dut (
        .clk(clk), .reset(reset), .en(en), .lzb(lzb), .colon(colon),
        .wr_en(wr_en), .wr_digit(wr_digit), .wr_data(wr_data), .wr_dp(wr_dp),
        .anode(anode), .cathode(cathode), .frame_done(frame_done), .cur_digit(cur_digit)
    );

    mod_display_scan_scheduler #(.CLK_DIV(2), .SLOT_TICKS(3), .BLANK_TICKS(0)) dut_nb (
        .clk(clk), .reset(reset), .en(en), .lzb(lzb), .colon(colon),
        .wr_en(wr_en), .wr_digit(wr_digit), .wr_data(wr_data), .wr_dp(wr_dp),
        .anode(anode_nb), .cathode(cathode_nb), .frame_done(frame_done_nb), .cur_digit(cur_digit_nb)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [3:0][8:0] cath, input logic [3:0] lit,
                              input bit boundary, input int blank_len);
        exp_t e;
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 6; i++) begin
                e.an = 4'hF;
                if (lit[d]) e.an[d] = 1'b0;
                e.cat = lit[d] ? cath[d] : 9'h1FF;
                e.fd  = boundary && (d == 0) && (i == 0);
                e.dig = 2'(d);
                q.push_back(e);
            end
            for (int i = 0; i < blank_len; i++) begin
                e.an  = 4'hF;
                e.cat = 9'h1FF;
                e.fd  = 1'b0;
                e.dig = 2'(d);
                q.push_back(e);
            end
        end
    endtask

    task automatic push_off(input int n);
        exp_t e;
        e.an = 4'hF; e.cat = 9'h1FF; e.fd = 1'b0; e.dig = 2'd0;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic drain(input int n, input bit sel, input string name);
        exp_t e, got;
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
            e   = q.pop_front();
            got = sel ? {anode_nb, cathode_nb, frame_done_nb, cur_digit_nb}
                      : {anode, cathode, frame_done, cur_digit};
            tests++;
            if (got !== e) begin
                fails++;
                $display("FAIL %s cyc%0d: got an=%b cat=%h fd=%b dig=%0d, want an=%b cat=%h fd=%b dig=%0d",
                         name, i, got.an, got.cat, got.fd, got.dig, e.an, e.cat, e.fd, e.dig);
            end
        end
    endtask

    task automatic do_write(input logic [1:0] d, input logic [3:0] v, input logic dp);
        wr_en = 1'b1; wr_digit = d; wr_data = v; wr_dp = dp;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic write4(input logic [3:0] v3, v2, v1, v0, input logic [3:0] dpm);
        do_write(2'd3, v3, dpm[3]);
        do_write(2'd2, v2, dpm[2]);
        do_write(2'd1, v1, dpm[1]);
        do_write(2'd0, v0, dpm[0]);
    endtask

    task automatic restart();
        q.delete();
        en = 1'b0; wr_en = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        repeat (2) begin @(posedge clk); #1; end
        tests++;
        if ({anode, cathode, frame_done, cur_digit} !== {4'hF, 9'h1FF, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL reset: got an=%b cat=%h fd=%b dig=%0d, want an=1111 cat=1ff fd=0 dig=0",
                     anode, cathode, frame_done, cur_digit);
        end
        tests++;
        if ({anode_nb, cathode_nb, frame_done_nb, cur_digit_nb} !== {4'hF, 9'h1FF, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL reset_nb: got an=%b cat=%h fd=%b dig=%0d, want an=1111 cat=1ff fd=0 dig=0",
                     anode_nb, cathode_nb, frame_done_nb, cur_digit_nb);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_scan();
        restart();
        write4(4'h8, 4'h1, 4'h0, 4'hF, 4'b0000);
        en = 1'b1;
        push_frame(STD, 4'hF, 1'b0, 2);
        push_frame(STD, 4'hF, 1'b1, 2);
        drain(64, 1'b0, "scan");
    endtask

    task automatic test_tear_free();
        logic [3:0][8:0] c1, c2;
        c1 = STD; c1[0] = 9'h1F9;
        c2 = STD; c2[0] = 9'h1A4;
        restart();
        write4(4'h8, 4'h1, 4'h0, 4'hF, 4'b0000);
        en = 1'b1;
        push_frame(STD, 4'hF, 1'b0, 2);
        push_frame(c1, 4'hF, 1'b1, 2);
        push_frame(c1, 4'hF, 1'b1, 2);
        push_frame(c2, 4'hF, 1'b1, 2);
        drain(10, 1'b0, "tear_pre");
        wr_en = 1'b1; wr_digit = 2'd0; wr_data = 4'h1; wr_dp = 1'b0;
        drain(1, 1'b0, "tear_wr");
        wr_en = 1'b0;
        drain(53, 1'b0, "tear_mid");
        // Write lands on the edge that opens frame 3; it must show in frame 4.
        wr_en = 1'b1; wr_digit = 2'd0; wr_data = 4'h2;
        drain(1, 1'b0, "tear_edge");
        wr_en = 1'b0;
        drain(37, 1'b0, "tear_post");
        q.delete();
    endtask

    task automatic test_lzb();
        restart();
        write4(4'h0, 4'h0, 4'h0, 4'h5, 4'b0000);
        lzb = 1'b1;
        en  = 1'b1;
        push_frame({9'h1C0, 9'h1C0, 9'h1C0, 9'h192}, 4'b0001, 1'b0, 2);
        drain(32, 1'b0, "lzb_on");
        restart();
        lzb = 1'b0;
        en  = 1'b1;
        push_frame({9'h1C0, 9'h1C0, 9'h1C0, 9'h192}, 4'b1111, 1'b0, 2);
        drain(32, 1'b0, "lzb_off");
        restart();
        write4(4'h0, 4'h3, 4'h0, 4'h5, 4'b0000);
        lzb = 1'b1;
        en  = 1'b1;
        push_frame({9'h1C0, 9'h1B0, 9'h1C0, 9'h192}, 4'b0111, 1'b0, 2);
        drain(32, 1'b0, "lzb_mid");
        lzb = 1'b0;
    endtask

    task automatic test_dp_colon();
        restart();
        write4(4'h1, 4'h2, 4'h3, 4'h4, 4'b0100);
        colon = 1'b1;
        en    = 1'b1;
        push_frame({9'h1F9, 9'h124, 9'h0B0, 9'h199}, 4'hF, 1'b0, 2);
        drain(32, 1'b0, "dp_colon");
        colon = 1'b0;
    endtask

    task automatic test_enable_reset();
        restart();
        write4(4'h8, 4'h1, 4'h0, 4'hF, 4'b0000);
        en = 1'b1;
        push_frame(STD, 4'hF, 1'b0, 2);
        drain(3, 1'b0, "en_pre");
        q.delete();
        en = 1'b0;
        push_off(3);
        drain(3, 1'b0, "en_off");
        en = 1'b1;
        push_frame(STD, 4'hF, 1'b0, 2);
        drain(10, 1'b0, "en_restart");
        q.delete();
        reset = 1'b0;
        en    = 1'b0;
        #1;
        tests++;
        if ({anode, cathode, frame_done, cur_digit} !== {4'hF, 9'h1FF, 1'b0, 2'd0}) begin
            fails++;
            $display("FAIL async_reset: got an=%b cat=%h fd=%b dig=%0d, want an=1111 cat=1ff fd=0 dig=0",
                     anode, cathode, frame_done, cur_digit);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        en = 1'b1;
        push_frame({4{9'h1C0}}, 4'hF, 1'b0, 2);
        drain(32, 1'b0, "reset_cleared");
    endtask

    task automatic test_zero_blank();
        restart();
        write4(4'h8, 4'h1, 4'h0, 4'hF, 4'b0000);
        en = 1'b1;
        push_frame(STD, 4'hF, 1'b0, 0);
        push_frame(STD, 4'hF, 1'b1, 0);
        drain(48, 1'b1, "zero_blank");
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; lzb = 1'b0; colon = 1'b0;
        wr_en = 1'b0; wr_digit = 2'd0; wr_data = 4'h0; wr_dp = 1'b0;
        test_reset();
        test_scan();
        test_tear_free();
        test_lzb();
        test_dp_colon();
        test_enable_reset();
        test_zero_blank();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mod_display_scan_scheduler.md
Name: mod_display_scan_scheduler

Overview:
- Time-multiplexes the shared 4-digit seven-segment cathode bus between four digit registers.
- Holds double-buffered digit values. Writers update shadow registers at any time; the shadow copies to the active set only at frame boundaries, so the display never shows a partly updated frame.
- Generates the anode scan sequence, inter-digit blanking (anti-ghosting), leading-zero blanking and a frame-done strobe.
- Runs from the board clock with an internal prescaler, so no divided clock is needed.

Parameters:
- CLK_DIV, 50000: clk cycles per scan tick; must be >= 1.
- SLOT_TICKS, 4: ticks a digit is lit per slot; must be >= 1.
- BLANK_TICKS, 1: ticks with all anodes off after each slot; may be 0.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  scan enable; 0 turns the display off.
- lzb  input  1  leading-zero blanking enable.
- colon  input  1  colon request, shown on cathode[8] during the digit-1 slot.
- wr_en  input  1  shadow write strobe.
- wr_digit  input  2  digit index to write (0 = least significant).
- wr_data  input  4  hex value to write.
- wr_dp  input  1  decimal point for the written digit.
- anode  output  4  active-low digit enables.
- cathode  output  9  active-low segments: [6:0] = a..g (bit 0 = a), [7] = dp, [8] = colon.
- frame_done  output  1  one-cycle pulse at each frame boundary.
- cur_digit  output  2  digit currently scheduled.

Behaviour:
- Reset (reset = 0, asynchronous):
  - State IDLE; anode = 4'hF; cathode = 9'h1FF; frame_done = 0; cur_digit = 0.
  - Prescaler and tick counter = 0.
  - Shadow and active values = 0; dp bits = 0.
- Outputs: all registered; they change on the same clk edge as the state transition.
- Prescaler: counts 0..CLK_DIV-1; tick asserts when the count equals CLK_DIV-1; held at 0 in IDLE.
- FSM states: IDLE, ON, BLANK.
- IDLE:
  - Outputs are all off.
  - When en = 1, the next edge enters ON with cur_digit = 0, copies shadow to active and clears the counters.
  - No frame_done pulse on this entry.
- ON:
  - anode[cur_digit] = 0, others 1; cathode = decode(active[cur_digit]).
  - After exactly SLOT_TICKS*CLK_DIV cycles: go to BLANK if BLANK_TICKS > 0, else go to ON with the next digit.
- BLANK:
  - anode = 4'hF; cathode = 9'h1FF.
  - After BLANK_TICKS*CLK_DIV cycles: go to ON with the next digit.
- Next digit: cur_digit + 1, wrapping 3 -> 0.
- Frame boundary (the transition into ON with digit 0 from digit 3):
  - frame_done = 1 for one cycle.
  - Shadow copies to active on the same edge.
- Frame period: 4*(SLOT_TICKS+BLANK_TICKS)*CLK_DIV cycles.
- en = 0 in any state: next edge goes to IDLE and outputs go off; a partial frame is abandoned with no frame_done.
- Decode: standard hex, active-low. Examples for cathode[6:0]: 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110.
- cathode[7] = ~dp of the lit digit.
- cathode[8] = ~colon during the digit-1 ON slot, 1 otherwise.
- Leading-zero blanking, when lzb = 1:
  - Digit 3 is blanked if active[3] = 0.
  - Digit 2 is blanked if active[3] = active[2] = 0.
  - Digit 1 is blanked if digits 3..1 are all 0.
  - Digit 0 is never blanked.
  - A blanked slot keeps its timing but drives anode = 4'hF and cathode = 9'h1FF, including dp.
  - Evaluated on active values only.
- Writes:
  - wr_en = 1 writes wr_data and wr_dp into shadow[wr_digit] at the edge.
  - Writes are accepted in every state, including IDLE.
  - Repeated writes to the same digit: the last write wins.
- Write coinciding with a frame-boundary copy: the copy uses the pre-edge shadow, so the write appears in the following frame.
- Reset mid-frame: immediate return to the reset values; no frame_done pulse.

Test Plan (CLK_DIV=2, SLOT_TICKS=3, BLANK_TICKS=1, frame = 32 cycles):
- Scan sequence: reset release, write shadow = {3:8, 2:1, 1:0, 0:F}, en = 1 -> anode steps 1110, 1111, 1101, 1111, 1011, 1111, 0111, 1111. Each lit slot is 6 cycles, each blank 2 cycles. Digit 0 shows 0001110, digit 3 shows 0000000. frame_done pulses every 32 cycles.
- Tear-free update: write digit 0 = 1 mid-frame -> digit 0 still shows F until the next frame boundary, then 1111001. A write on the boundary edge itself appears one frame later.
- Leading-zero blanking: values {0,0,0,5}, lzb = 1 -> digits 3..1 have anode 1111 during their slots; digit 0 is lit. With lzb = 0, digits 3..1 show 1000000.
- DP and colon: wr_dp = 1 on digit 2, colon = 1 -> cathode[7] = 0 only in the digit-2 slot; cathode[8] = 0 only in the digit-1 slot.
- Enable and reset: en = 0 mid-slot -> next edge anode = 1111, cathode = 1FF, no frame_done; re-enable restarts at digit 0. Asserting reset mid-slot -> outputs off immediately; shadow values read back as 0 after re-enable.
- Zero blanking: BLANK_TICKS=0 build -> slots are contiguous, never all-off between digits, and the frame is 24 cycles.
